hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of the saturating stall-cycle counter.
REQ-002 SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; asynchronous assert, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_src1  in  5  ID source register 1.
- id_src2  in  5  ID source register 2.
- id_two_src  in  1  id_src2 is read (not immediate, or store).
- id_dest  in  5  ID destination register.
- id_wb_en  in  1  ID instruction writes back.
- id_mem_r_en  in  1  ID instruction is a load.
- branch_taken  in  1  EXE resolves a taken branch.
- mem_req  in  1  MEM stage issues an SRAM access.
- mem_ready  in  1  SRAM access completes this cycle.
- freeze_front  out  1  Freeze for PC and IF/ID registers.
- freeze_id  out  1  Freeze for ID/EXE pipeline register.
- flush_if  out  1  Flush for IF/ID register.
- flush_id  out  1  Flush for ID/EXE pipeline register.
- stall_mem  out  1  freeze for EXE/MEM and MEM/WB registers.
- stall_cnt  out  CNT_W  cycles with freeze_front high, saturating.

Function
REQ-003 SHALL keep a 2-slot scoreboard (EXE, MEM), each {valid, dest, is_load}, mirroring the ID/EXE and EXE/MEM contents.
REQ-004 SHALL advance on a rising edge when stall_mem=0: MEM<=EXE; EXE<=ID info if id_valid & id_wb_en & ~freeze_id & ~flush_id, else an invalid bubble.
REQ-005 SHALL hold both slots unchanged while stall_mem=1.
REQ-006 SHALL match a source only if it is nonzero, equals the slot dest, and the slot is valid; id_src2 is compared only when id_two_src=1.
REQ-007 SHALL drive hazard (internal) = id_valid & (src match per the REQ-015/REQ-016 rule).
REQ-008 SHALL implement the memory FSM with states IDLE and MEM_WAIT:
- IDLE->MEM_WAIT when mem_req & ~mem_ready.
- MEM_WAIT->IDLE when mem_ready.
- All other cases: stay.
REQ-009 SHALL assert stall_mem combinationally = (IDLE & mem_req & ~mem_ready) | (MEM_WAIT & ~mem_ready).
REQ-010 SHALL assert flush_if = flush_id = branch_taken & ~stall_mem; a branch during a memory stall is flushed on the first non-stalled cycle.
REQ-011 SHALL assert freeze_front = freeze_id = stall_mem | (hazard & ~flush_id); a flush cancels a data-hazard freeze in the same cycle.
REQ-012 SHALL increment stall_cnt on every edge with freeze_front=1 and hold it at all-ones (no wrap).
REQ-013 SHALL have zero-cycle decision latency: all freeze/flush outputs are combinational from the current slots, FSM state, and inputs.

Reset
REQ-014 SHALL, while rst=0:
- set both slots invalid (dest 0) and the FSM to IDLE;
- clear stall_cnt to 0;
- force freeze_front, freeze_id, flush_if, flush_id and stall_mem to 0 regardless of inputs.
Reset mid-MEM_WAIT SHALL return the FSM to IDLE immediately.

Configuration
REQ-015 With HAZARD_FORWARDING_EN defined, the datapath forwards, and a hazard exists only on a source match against the EXE slot with is_load=1 (load-use, one-cycle stall).
REQ-016 Without HAZARD_FORWARDING_EN, a hazard exists on any source match against the EXE or MEM slot; the register file write-before-read covers WB.

Structure
REQ-017 SHALL place the following in shared package pipe_pkg:
- FSM state encoding (IDLE=0, MEM_WAIT=1);
- the scoreboard-slot struct;
- register-index width constant 5.
REQ-018 SHALL contain one sub-module, hazard_cmp: combinational src-vs-slot matcher, instantiated once per slot.

Verification
REQ-019 Load r3 in EXE, ID add reads r3, forwarding on -> freeze 1 cycle, then bubble in EXE, freeze 0, stall_cnt=1.
REQ-020 ALU writes r5 in EXE, ID reads r5, forwarding off -> freeze 2 cycles (EXE then MEM match); forwarding on -> no freeze.
REQ-021 ID src1=0, EXE dest=0 valid load -> no freeze.
REQ-022 mem_req=1 with mem_ready low 3 cycles -> stall_mem=1 for 3 cycles, FSM MEM_WAIT, slots frozen, release on mem_ready.
REQ-023 branch_taken and a load-use hazard in the same cycle -> flush_if=flush_id=1, freeze 0; branch_taken during MEM_WAIT -> flush held off until mem_ready.
REQ-024 Assert rst=0 during MEM_WAIT with stall_cnt=7 -> all outputs 0 and FSM IDLE asynchronously.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard controller.
//   mem_state_e : memory-handshake FSM encoding (IDLE=0, MEM_WAIT=1)
//   sb_slot_t   : scoreboard slot {valid, dest, is_load}
//   REG_W       : register-index width
package pipe_pkg;
  localparam int REG_W = 5;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             is_load;
  } sb_slot_t;
endpackage

// File: rtl/hazard_cmp.sv
// Combinational matcher: ID sources against one scoreboard slot.
// Ports:
//   i_en        : matcher enabled (tie 0 to ignore this slot)
//   i_load_only : only a load in the slot can raise a match
//   i_src1/2    : ID source registers; i_src2 used only with i_two_src
//   i_slot      : scoreboard slot contents
//   o_match     : a read source depends on the slot's destination
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic             i_en,
  input  logic             i_load_only,
  input  logic [REG_W-1:0] i_src1,
  input  logic [REG_W-1:0] i_src2,
  input  logic             i_two_src,
  input  sb_slot_t         i_slot,
  output logic             o_match
);
  logic w_m1, w_m2, w_kind_ok;

  // r0 is hardwired zero, so it never carries a dependency
  assign w_m1      = (i_src1 != '0) && (i_src1 == i_slot.dest);
  assign w_m2      = i_two_src && (i_src2 != '0) && (i_src2 == i_slot.dest);
  assign w_kind_ok = ~i_load_only | i_slot.is_load;
  assign o_match   = i_en & i_slot.valid & w_kind_ok & (w_m1 | w_m2);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-hazard freeze, branch flush and
// memory-wait stall, with a saturating count of frozen cycles.
// Build option: HAZARD_FORWARDING_EN -- datapath forwards, so only a
// load-use dependency on the EXE slot freezes; otherwise any dependency
// on the EXE or MEM slot freezes.
// Ports:
//   clk, rst (async, active-low)
//   id_*         : ID-stage instruction info
//   branch_taken : EXE resolves a taken branch
//   mem_req/ready: MEM-stage SRAM handshake
//   freeze_front, freeze_id, flush_if, flush_id, stall_mem : pipeline controls
//   stall_cnt    : cycles with freeze_front high, saturating
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_front,
  output logic             freeze_id,
  output logic             flush_if,
  output logic             flush_id,
  output logic             stall_mem,
  output logic [CNT_W-1:0] stall_cnt
);
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  sb_slot_t         r_exe, r_mem, w_id_slot;
  mem_state_e       r_state, w_state_nxt;
  logic             w_stall_raw, w_flush, w_hazard, w_freeze;
  logic             w_exe_match, w_mem_match;
  logic [CNT_W-1:0] r_stall_cnt;

  hazard_cmp u_cmp_exe (
    .i_en        (1'b1),
    .i_load_only (FWD),
    .i_src1      (id_src1),
    .i_src2      (id_src2),
    .i_two_src   (id_two_src),
    .i_slot      (r_exe),
    .o_match     (w_exe_match)
  );

  // With forwarding the MEM result is always bypassable
  hazard_cmp u_cmp_mem (
    .i_en        (!FWD),
    .i_load_only (1'b0),
    .i_src1      (id_src1),
    .i_src2      (id_src2),
    .i_two_src   (id_two_src),
    .i_slot      (r_mem),
    .o_match     (w_mem_match)
  );

  // Memory FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall_raw = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_req && !mem_ready) begin
          w_state_nxt = MEM_WAIT;
          w_stall_raw = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) w_state_nxt = IDLE;
        else           w_stall_raw = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Control outputs; reset low forces every control to 0
  assign w_hazard     = id_valid & (w_exe_match | w_mem_match);
  assign w_flush      = rst & branch_taken & ~w_stall_raw;
  assign w_freeze     = rst & (w_stall_raw | (w_hazard & ~w_flush));
  assign stall_mem    = rst & w_stall_raw;
  assign flush_if     = w_flush;
  assign flush_id     = w_flush;
  assign freeze_front = w_freeze;
  assign freeze_id    = w_freeze;

  // A frozen or flushed ID instruction enters EXE as a bubble
  always_comb begin
    w_id_slot = '0;
    if (id_valid && id_wb_en && !w_freeze && !w_flush) begin
      w_id_slot.valid   = 1'b1;
      w_id_slot.dest    = id_dest;
      w_id_slot.is_load = id_mem_r_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exe <= '0;
      r_mem <= '0;
    end else if (!stall_mem) begin
      r_mem <= r_exe;
      r_exe <= w_id_slot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  r_stall_cnt <= '0;
    else if (w_freeze && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign stall_cnt = r_stall_cnt;
endmodule
